// File: rtl/calc_pkg.sv
// Shared constants and state/slot encodings for the calculator serial front end.
package calc_pkg;

    localparam int WORD_W = 12;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CMD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLOT_A  = 2'd0,
        SLOT_B  = 2'd1,
        SLOT_OP = 2'd2
    } slot_t;

endpackage

// File: rtl/calc_bit_shifter.sv
// Priority-decodes start/zero/one pulses and assembles MSB-first words.
module calc_bit_shifter #(
    parameter int WORD_W = calc_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_bit,
    input  logic              one_bit,
    input  logic              zero_bit,
    input  logic              i_enable,
    input  logic              i_load,
    output logic              o_start,
    output logic              o_bit_acc,
    output logic              o_done,
    output logic [WORD_W-1:0] o_word_next,
    output logic [WORD_W-1:0] o_word_out,
    output logic              o_word_valid
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              w_bit_pulse;
    logic              w_bit_val;

    // start outranks zero, zero outranks one
    assign o_start     = start_bit;
    assign w_bit_pulse = !start_bit && (zero_bit || one_bit);
    assign w_bit_val   = !zero_bit;

    assign o_bit_acc   = i_enable && !i_load && w_bit_pulse && (r_bit_cnt != '0);
    assign o_done      = o_bit_acc && (r_bit_cnt == CNT_W'(1));
    assign o_word_next = {r_shift[WORD_W-2:0], w_bit_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            o_word_out   <= '0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= o_done;
            if (i_load) begin
                r_shift   <= '0;
                r_bit_cnt <= CNT_W'(WORD_W);
            end else if (o_bit_acc) begin
                r_shift   <= o_word_next;
                r_bit_cnt <= r_bit_cnt - CNT_W'(1);
            end
            if (o_done) begin
                o_word_out <= o_word_next;
            end
        end
    end

endmodule

// File: rtl/calc_frame_ctrl.sv
// Groups serial words into A/B/opcode frames and hands them to the ALU via valid/ready.
module calc_frame_ctrl #(
    parameter int WORD_W      = calc_pkg::WORD_W,
    parameter int OP_W        = calc_pkg::OP_W,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_bit,
    input  logic              one_bit,
    input  logic              zero_bit,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic [OP_W-1:0]   opcode,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        word_idx,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);
    import calc_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state, w_state_next;
    slot_t             r_idx, w_idx_next;
    logic [TMO_W-1:0]  r_idle_cnt;
    logic              w_start, w_bit_acc, w_done;
    logic              w_start_acc, w_pulse_acc, w_tmo_run, w_tmo_hit;
    logic [WORD_W-1:0] w_word_next;

    calc_bit_shifter #(.WORD_W(WORD_W)) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .start_bit    (start_bit),
        .one_bit      (one_bit),
        .zero_bit     (zero_bit),
        .i_enable     (r_state == SHIFT),
        .i_load       (w_start_acc),
        .o_start      (w_start),
        .o_bit_acc    (w_bit_acc),
        .o_done       (w_done),
        .o_word_next  (w_word_next),
        .o_word_out   (word_out),
        .o_word_valid (word_valid)
    );

    assign w_start_acc = w_start && (r_state != CMD);
    assign w_pulse_acc = w_start_acc || w_bit_acc;
    // Only a partially received frame can time out
    assign w_tmo_run   = (r_state == SHIFT) || ((r_state == IDLE) && (r_idx != SLOT_A));
    assign w_tmo_hit   = w_tmo_run && !w_pulse_acc && (r_idle_cnt == TMO_W'(TIMEOUT_CYC - 1));

    assign cmd_valid = (r_state == CMD);
    assign busy      = (r_state != IDLE);
    assign word_idx  = r_idx;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_state_next = SHIFT;
                end else if (w_tmo_hit) begin
                    w_idx_next = SLOT_A;
                end
            end
            SHIFT: begin
                if (w_tmo_hit) begin
                    w_state_next = IDLE;
                    w_idx_next   = SLOT_A;
                end else if (w_done) begin
                    case (r_idx)
                        SLOT_A: begin
                            w_state_next = IDLE;
                            w_idx_next   = SLOT_B;
                        end
                        SLOT_B: begin
                            w_state_next = IDLE;
                            w_idx_next   = SLOT_OP;
                        end
                        default: begin
                            w_state_next = CMD;
                            w_idx_next   = SLOT_A;
                        end
                    endcase
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = SLOT_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= SLOT_A;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt  <= '0;
            op_a        <= '0;
            op_b        <= '0;
            opcode      <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= w_tmo_hit;
            if (!w_tmo_run || w_pulse_acc || w_tmo_hit) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TMO_W'(1);
            end
            if (w_done) begin
                case (r_idx)
                    SLOT_A:  op_a   <= w_word_next;
                    SLOT_B:  op_b   <= w_word_next;
                    default: opcode <= w_word_next[OP_W-1:0];
                endcase
            end
            if ((r_state == CMD) && (start_bit || one_bit || zero_bit)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule
